// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between instruction fetch and data access
// Ports: clk, rst (sync, active-high)
//        fetch side f_req/f_addr -> f_ack; data side d_req/d_we/d_addr/d_wdata -> d_ack
//        rdata: read data of last completed transfer
//        memory side mem_req/mem_we/mem_addr/mem_wdata -> mem_ack/mem_rdata
//        status: grant (01 fetch, 10 data), busy, sticky timeout_err
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          timeout_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [1:0]    f_sync_q, d_sync_q, a_sync_q;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;
    logic          f_ack_q, f_ack_d, d_ack_q, d_ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          terr_q, terr_d;
    logic          s_f_req, s_d_req, s_mem_ack, pick_d, owner_req;

    assign s_f_req   = f_sync_q[1];
    assign s_d_req   = d_sync_q[1];
    assign s_mem_ack = a_sync_q[1];
    // last_q = 1 means data owned the port last; data wins a tie only when fetch went last
    assign pick_d    = s_d_req && (!s_f_req || !last_q);
    assign owner_req = grant_q[1] ? s_d_req : s_f_req;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        last_d      = last_q;
        f_ack_d     = f_ack_q;
        d_ack_d     = d_ack_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        terr_d      = terr_q;
        case (state_q)
            IDLE: if (s_f_req || s_d_req) begin
                grant_d     = pick_d ? 2'b10 : 2'b01;
                mem_addr_d  = pick_d ? d_addr : f_addr;
                mem_we_d    = pick_d & d_we;
                mem_wdata_d = pick_d ? d_wdata : mem_wdata_q;
                mem_req_d   = 1'b1;
                cnt_d       = '0;
                state_d     = REQ;
            end
            REQ: begin
                cnt_d = cnt_q + TW'(1);
                if (s_mem_ack || cnt_q == TW'(TIMEOUT - 1)) begin
                    // a timeout completes the handshake with zero data so the requester never hangs
                    terr_d    = terr_q | !s_mem_ack;
                    rdata_d   = s_mem_ack ? mem_rdata : '0;
                    mem_req_d = 1'b0;
                    f_ack_d   = grant_q[0];
                    d_ack_d   = grant_q[1];
                    state_d   = ACK;
                end
            end
            ACK: if (!owner_req && !s_mem_ack) begin
                f_ack_d = 1'b0;
                d_ack_d = 1'b0;
                grant_d = 2'b00;
                last_d  = grant_q[1];
                state_d = IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                f_ack_d   = 1'b0;
                d_ack_d   = 1'b0;
                grant_d   = 2'b00;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            f_sync_q    <= '0;
            d_sync_q    <= '0;
            a_sync_q    <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            last_q      <= 1'b1;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            f_sync_q    <= {f_sync_q[0], f_req};
            d_sync_q    <= {d_sync_q[0], d_req};
            a_sync_q    <= {a_sync_q[0], mem_ack};
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            terr_q      <= terr_d;
        end
    end

    assign f_ack       = f_ack_q;
    assign d_ack       = d_ack_q;
    assign rdata       = rdata_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign grant       = grant_q;
    assign busy        = state_q != IDLE;
    assign timeout_err = terr_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Clocked arbiter that shares the single 8-bit-address / 16-bit-data memory port between two requesters: instruction fetch (PC path, read-only) and data access (cache path, read or write).
- Both requester sides and the memory side use four-phase req/ack handshakes.
- All handshake inputs are double-flop synchronised, so the block can face self-timed neighbours.
- Contains round-robin arbitration, operand capture, read-data return and a memory-response timeout.

Parameters:
AW, 8, address width
DW, 16, data width
TIMEOUT, 64, max cycles in REQ waiting for mem_ack (must be >= 2)
TW, $clog2(TIMEOUT+1), timeout counter width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
f_req  in  1  fetch request (4-phase)
f_addr  in  AW  fetch address; stable while f_req high
f_ack  out  1  fetch acknowledge
d_req  in  1  data request (4-phase)
d_we  in  1  1 = write, 0 = read; stable while d_req high
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_ack  out  1  data acknowledge
rdata  out  DW  read data of last completed transfer; valid while f_ack or d_ack high
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_ack  in  1  memory acknowledge
mem_rdata  in  DW  memory read data; valid while mem_ack high
grant  out  2  one-hot owner: 01 = fetch, 10 = data, 00 = none
busy  out  1  FSM not in IDLE
timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset: the cycle after rst is sampled high, all outputs are 0, the sync flops are 0, the timeout counter is 0, last_grant = DATA (so fetch wins the first tie), and the FSM is in IDLE. Reset in any state abandons the transfer immediately; no ack is issued.
- Sync: f_req, d_req and mem_ack each pass through 2 flops (s_f_req, s_d_req, s_mem_ack). All FSM decisions use the synced versions only. f_addr, d_* and mem_rdata are sampled unsynchronised; the 4-phase protocol guarantees they are stable.
- IDLE:
  - If s_f_req or s_d_req is high, select the owner. If only one is high, that one wins. If both are high, the one not equal to last_grant wins.
  - Capture the owner's address into mem_addr. For data, also capture d_we into mem_we and d_wdata into mem_wdata. For fetch, mem_we = 0 and mem_wdata holds its old value.
  - Set grant and mem_req = 1, clear the counter, go to REQ.
  - Requester raises req with its first sampling edge at k: mem_req rises on edge k+2.
- REQ:
  - mem_req = 1 and the counter increments each cycle.
  - If s_mem_ack = 1: rdata <= mem_rdata (write transfers also load rdata), mem_req <= 0, the owner's ack <= 1, go to ACK. If mem_ack is first sampled high at edge m, the ack rises and mem_req falls on edge m+2.
  - Else, if counter == TIMEOUT-1: timeout_err <= 1, rdata <= 0, mem_req <= 0, owner ack <= 1, go to ACK.
- ACK:
  - Hold the owner ack high.
  - When the owner's synced req = 0 and s_mem_ack = 0 in the same cycle: drop the ack, set grant = 00, last_grant <= owner, go to IDLE.
  - A late mem_ack after a timeout is absorbed here.
- Protocol:
  - At most one transfer is outstanding.
  - The non-owner's req is ignored until IDLE; its ack stays 0.
  - The fastest turnaround to a waiting second requester is 1 idle cycle.
- Invariants:
  - f_ack and d_ack are never high together.
  - mem_req = 1 only in REQ.
  - mem_addr, mem_we and mem_wdata change only on the IDLE->REQ transition.
  - busy = (state != IDLE).
- timeout_err: cleared only by rst; no other effect on operation.
- State encoding: IDLE / REQ / ACK, 2-bit register. The unused code returns to IDLE.

Test Plan:
- Reset check: hold rst 3 cycles, then release with no requests -> all outputs 0, grant = 00, busy = 0 for 10 cycles.
- Single fetch: f_addr = 8'h12 with f_req up at edge k; memory model answers 3 cycles after mem_req with mem_rdata = 16'hA5A5 -> mem_req rises at k+2 with mem_addr = 12, mem_we = 0; f_ack rises 2 edges after mem_ack is sampled with rdata = A5A5. Drop f_req -> f_ack falls, grant returns to 00.
- Data write: d_we = 1, d_addr = 8'h40, d_wdata = 16'h1234 -> mem_we = 1, mem_addr = 40, mem_wdata = 1234 throughout REQ; d_ack completes the handshake; f_ack stays 0.
- Simultaneous requests: f_req and d_req rise on the same edge after reset, and both requesters immediately re-request after each ack -> order is fetch, data, fetch, data; grant alternates 01/10 with exactly one idle cycle between transfers.
- Timeout: TIMEOUT = 8, d_req raised, mem_ack never asserted -> after 8 REQ cycles, timeout_err = 1, rdata = 0, d_ack = 1. Then pulse mem_ack late -> FSM waits for it to fall before returning to IDLE. A following fetch completes normally and timeout_err stays 1.
- Reset mid-transfer: assert rst while in REQ with mem_req = 1 -> next cycle mem_req = 0, busy = 0, timeout_err = 0, no ack pulse. A fresh fetch afterwards completes normally.
